// File: rtl/scsi_port_timing.sv
// Peripheral-port cycle generator for the WD33C93A: turns a one-cycle request into
// registered select/strobe/hold/recovery timing and returns read data with an ACK pulse.
module scsi_port_timing #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned RECOV_CYC  = 2,
    parameter int unsigned CW         = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        RW,
    input  logic        DMA,
    input  logic        PRESET,
    input  logic [15:0] WDATA,
    input  logic [15:0] PD_IN,
    output logic [15:0] PD_OUT,
    output logic        PD_DRIVE,
    output logic [15:0] RDATA,
    output logic        BUSY,
    output logic        ACK,
    output logic        _CSS,
    output logic        _DACK,
    output logic        _IOR,
    output logic        _IOW
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          rw_q, rw_nx;
    logic          dma_q, dma_nx;
    logic [15:0]   pd_out_nx, rdata_nx;
    logic          ack_nx, busy_nx, drive_nx;
    logic          css_nx, dack_nx, ior_nx, iow_nx;
    logic          sel, last;

    // Next phase, counter and registered-output values
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        rw_nx     = rw_q;
        dma_nx    = dma_q;
        pd_out_nx = PD_OUT;
        rdata_nx  = RDATA;
        ack_nx    = 1'b0;
        last      = (cnt == '0);

        if (PRESET) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    // BUSY is still high for one cycle after PRESET, so REQ is ignored there
                    if (REQ && !BUSY) begin
                        state_nx  = SETUP;
                        cnt_nx    = CW'(SETUP_CYC - 1);
                        rw_nx     = RW;
                        dma_nx    = DMA;
                        pd_out_nx = WDATA;
                    end
                end
                SETUP: begin
                    if (last) begin
                        state_nx = STROBE;
                        cnt_nx   = CW'(STROBE_CYC - 1);
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
                STROBE: begin
                    if (last) begin
                        state_nx = HOLD;
                        cnt_nx   = CW'(HOLD_CYC - 1);
                        if (rw_q) rdata_nx = PD_IN;
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (last) begin
                        ack_nx = 1'b1;
                        if (RECOV_CYC == 0) begin
                            state_nx = IDLE;
                            cnt_nx   = '0;
                        end else begin
                            state_nx = RECOVER;
                            cnt_nx   = CW'(RECOV_CYC - 1);
                        end
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
                RECOVER: begin
                    if (last) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end

        // Port pins are decoded from the phase being entered so they are registered
        sel      = (state_nx == SETUP) || (state_nx == STROBE) || (state_nx == HOLD);
        css_nx   = !(sel && !dma_nx);
        dack_nx  = !(sel && dma_nx);
        ior_nx   = !(PRESET || ((state_nx == STROBE) && rw_nx));
        iow_nx   = !(PRESET || ((state_nx == STROBE) && !rw_nx));
        drive_nx = sel && !rw_nx;
        busy_nx  = PRESET || (state_nx != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            rw_q     <= 1'b0;
            dma_q    <= 1'b0;
            PD_OUT   <= '0;
            PD_DRIVE <= 1'b0;
            RDATA    <= '0;
            BUSY     <= 1'b0;
            ACK      <= 1'b0;
            _CSS     <= 1'b1;
            _DACK    <= 1'b1;
            _IOR     <= 1'b1;
            _IOW     <= 1'b1;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            rw_q     <= rw_nx;
            dma_q    <= dma_nx;
            PD_OUT   <= pd_out_nx;
            PD_DRIVE <= drive_nx;
            RDATA    <= rdata_nx;
            BUSY     <= busy_nx;
            ACK      <= ack_nx;
            _CSS     <= css_nx;
            _DACK    <= dack_nx;
            _IOR     <= ior_nx;
            _IOW     <= iow_nx;
        end
    end

endmodule

// File: tb/tb_scsi_port_timing.sv
// Scoreboard bench for scsi_port_timing: stimulus pushes per-cycle expected pins,
// a negedge monitor pops and compares against the selected instance.
module tb_scsi_port_timing;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    // instance 0: default timing; instance 1: SETUP=2 STROBE=1 HOLD=1 RECOV=0
    logic        req0, rw0, dma0, pre0, req1, rw1, dma1, pre1;
    logic [15:0] wd0, pdin0, wd1, pdin1;
    logic [15:0] pdo0, rd0, pdo1, rd1;
    logic        drv0, busy0, ack0, css0, dack0, ior0, iow0;
    logic        drv1, busy1, ack1, css1, dack1, ior1, iow1;

    scsi_port_timing u_dut0 (
        .CLK(CLK), .RST(RST), .REQ(req0), .RW(rw0), .DMA(dma0), .PRESET(pre0),
        .WDATA(wd0), .PD_IN(pdin0), .PD_OUT(pdo0), .PD_DRIVE(drv0), .RDATA(rd0),
        .BUSY(busy0), .ACK(ack0), ._CSS(css0), ._DACK(dack0), ._IOR(ior0), ._IOW(iow0)
    );

    scsi_port_timing #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(1), .RECOV_CYC(0), .CW(3)) u_dut1 (
        .CLK(CLK), .RST(RST), .REQ(req1), .RW(rw1), .DMA(dma1), .PRESET(pre1),
        .WDATA(wd1), .PD_IN(pdin1), .PD_OUT(pdo1), .PD_DRIVE(drv1), .RDATA(rd1),
        .BUSY(busy1), .ACK(ack1), ._CSS(css1), ._DACK(dack1), ._IOR(ior1), ._IOW(iow1)
    );

    // ctl bit order: {_CSS, _DACK, _IOR, _IOW, BUSY, ACK, PD_DRIVE}
    typedef struct {
        int          inst;
        string       tag;
        logic [6:0]  ctl;
        logic [15:0] pdo;
        logic        chk_pdo;
        logic [15:0] rd;
        logic        chk_rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic wait_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int inst, input string tag, input logic [6:0] ctl,
                        input logic [15:0] pdo, input logic chk_pdo,
                        input logic [15:0] rd, input logic chk_rd);
        exp_t e;
        e.inst = inst; e.tag = tag; e.ctl = ctl;
        e.pdo = pdo; e.chk_pdo = chk_pdo; e.rd = rd; e.chk_rd = chk_rd;
        exp_q.push_back(e);
    endtask

    // Monitor: pops every expectation queued for the current cycle
    always @(negedge CLK) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [6:0]  act;
            logic [15:0] apdo, ard;
            e = exp_q.pop_front();
            if (e.inst == 0) begin
                act  = {css0, dack0, ior0, iow0, busy0, ack0, drv0};
                apdo = pdo0;
                ard  = rd0;
            end else begin
                act  = {css1, dack1, ior1, iow1, busy1, ack1, drv1};
                apdo = pdo1;
                ard  = rd1;
            end
            n_cmp++;
            if (act !== e.ctl || (e.chk_pdo && apdo !== e.pdo) || (e.chk_rd && ard !== e.rd)) begin
                n_bad++;
                $display("FAIL %s: ctl=%b pd_out=%h rdata=%h, required ctl=%b pd_out=%h(chk %0b) rdata=%h(chk %0b)",
                         e.tag, act, apdo, ard, e.ctl, e.pdo, e.chk_pdo, e.rd, e.chk_rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [6:0] rd_tab [0:8];
    logic [6:0] wr_tab [0:8];
    logic [6:0] pr_tab [0:9];
    logic [6:0] p1_tab [0:11];

    initial begin
        rd_tab = '{7'b1111000, 7'b0111100, 7'b0101100, 7'b0101100, 7'b0101100,
                   7'b0111100, 7'b1111110, 7'b1111100, 7'b1111000};
        wr_tab = '{7'b1111000, 7'b1011101, 7'b1010101, 7'b1010101, 7'b1010101,
                   7'b1011101, 7'b1111110, 7'b1111100, 7'b1111000};
        pr_tab = '{7'b1111000, 7'b0111100, 7'b0101100, 7'b0101100, 7'b1100100,
                   7'b1100100, 7'b1100100, 7'b1100100, 7'b1111000, 7'b1111000};
        p1_tab = '{7'b1111000, 7'b0111100, 7'b0111100, 7'b0101100, 7'b0111100, 7'b1111010,
                   7'b0111100, 7'b0111100, 7'b0101100, 7'b0111100, 7'b1111010, 7'b1111000};

        RST = 1'b1;
        req0 = 1'b1; rw0 = 1'b1; dma0 = 1'b0; pre0 = 1'b1; wd0 = 16'hFFFF; pdin0 = 16'hFFFF;
        req1 = 1'b1; rw1 = 1'b1; dma1 = 1'b0; pre1 = 1'b1; wd1 = 16'hFFFF; pdin1 = 16'hFFFF;

        // Reset dominates REQ and PRESET
        for (int c = 0; c < 2; c++) begin
            wait_cyc();
            push(0, $sformatf("reset0_c%0d", c), 7'b1111000, 16'h0000, 1'b1, 16'h0000, 1'b1);
            push(1, $sformatf("reset1_c%0d", c), 7'b1111000, 16'h0000, 1'b1, 16'h0000, 1'b1);
        end
        RST = 1'b0; req0 = 1'b0; pre0 = 1'b0; req1 = 1'b0; pre1 = 1'b0;

        // Register read, PD_IN valid only in the last strobe cycle
        for (int c = 0; c <= 8; c++) begin
            wait_cyc();
            req0 = (c == 0); rw0 = 1'b1; dma0 = 1'b0;
            pdin0 = (c == 4) ? 16'hA55A : 16'h0000;
            push(0, $sformatf("reg_read_c%0d", c), rd_tab[c], 16'h0, 1'b0,
                 (c >= 5) ? 16'hA55A : 16'h0000, 1'b1);
        end

        // DMA write
        for (int c = 0; c <= 8; c++) begin
            wait_cyc();
            req0 = (c == 0); rw0 = 1'b0; dma0 = 1'b1;
            wd0 = (c == 0) ? 16'h1234 : 16'hDEAD;
            push(0, $sformatf("dma_write_c%0d", c), wr_tab[c], 16'h1234,
                 (c >= 1 && c <= 5), 16'hA55A, 1'b1);
        end

        // Back-to-back: REQ held high, one cycle per 8 clocks
        for (int c = 0; c <= 16; c++) begin
            wait_cyc();
            req0 = (c < 16); rw0 = 1'b1; dma0 = 1'b0; pdin0 = 16'h5AA5;
            push(0, $sformatf("b2b_c%0d", c), (c == 0) ? rd_tab[0] : rd_tab[((c - 1) % 8) + 1],
                 16'h0, 1'b0, (c >= 5) ? 16'h5AA5 : 16'hA55A, 1'b1);
        end

        // PRESET in cycles 3-6 of a read, REQ kept high during and just after it
        for (int c = 0; c <= 9; c++) begin
            wait_cyc();
            req0 = (c == 0) || (c >= 3 && c <= 7); rw0 = 1'b1; dma0 = 1'b0;
            pre0 = (c >= 3 && c <= 6); pdin0 = 16'h0BAD;
            push(0, $sformatf("preset_c%0d", c), pr_tab[c], 16'h0, 1'b0, 16'h5AA5, 1'b1);
        end

        // Short timing with no recovery: new REQ accepted in the ACK cycle
        for (int c = 0; c <= 11; c++) begin
            wait_cyc();
            req1 = (c == 0) || (c == 5); rw1 = 1'b1; dma1 = 1'b0;
            pdin1 = (c == 3) ? 16'hC3C3 : ((c == 8) ? 16'h3C3C : 16'h0000);
            push(1, $sformatf("recov0_c%0d", c), p1_tab[c], 16'h0, 1'b0,
                 (c >= 9) ? 16'h3C3C : ((c >= 4) ? 16'hC3C3 : 16'h0000), 1'b1);
        end

        wait_cyc();
        wait_cyc();
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scsi_port_timing.md
Name: scsi_port_timing

Overview:
- Peripheral-port cycle generator that sits directly downstream of the SCSI state machine and drives the WD33C93A strobes and data port.
- Converts a single-cycle cycle request (register access or DMA byte/word) into a properly timed sequence: chip-select/DACK setup, IOR/IOW strobe, hold, then recovery.
- Latches read data from the port and returns a one-cycle completion pulse.
- Replaces direct combinational decoding of RE/WE/SCSI_CS/DACK with programmable, registered timing.

Parameters:
SETUP_CYC, 1, cycles CS/DACK asserted before strobe (>=1)
STROBE_CYC, 3, cycles IOR/IOW held low (>=1)
HOLD_CYC, 1, cycles CS/DACK and write data held after strobe release (>=1)
RECOV_CYC, 2, idle cycles enforced before the next cycle (>=0)
CW, 3, width of the phase counter; every *_CYC value must be < 2^CW

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  synchronous reset, active high
REQ  in  1  start-cycle pulse; sampled only when BUSY=0
RW  in  1  1=read from port, 0=write to port; sampled with REQ
DMA  in  1  1=DMA cycle (assert _DACK), 0=register cycle (assert _CSS); sampled with REQ
PRESET  in  1  peripheral reset request; forces IOR and IOW active
WDATA  in  16  write data; sampled with REQ
PD_IN  in  16  port data input
PD_OUT  out  16  port data output
PD_DRIVE  out  1  1=drive PD_OUT onto the port
RDATA  out  16  last read data
BUSY  out  1  cycle in progress or recovery pending
ACK  out  1  one-cycle completion pulse
_CSS  out  1  chip select, active low
_DACK  out  1  DMA acknowledge, active low
_IOR  out  1  read strobe, active low
_IOW  out  1  write strobe, active low

Behaviour:
- Reset: all outputs are registered. While RST=1 at an edge, the block forces:
  - state=IDLE, counter=0
  - _CSS=_DACK=_IOR=_IOW=1
  - PD_DRIVE=0, PD_OUT=0, RDATA=0
  - BUSY=0, ACK=0
- RST takes priority over PRESET and REQ.
- States: IDLE, SETUP, STROBE, HOLD, RECOVER. The counter loads N-1 on entry to each phase and the phase exits at count 0.
- IDLE:
  - REQ=1 latches RW, DMA and WDATA, and sets BUSY=1.
  - Next state is SETUP.
- SETUP (SETUP_CYC cycles):
  - _CSS=0 when DMA=0, otherwise _DACK=0.
  - On a write, PD_DRIVE=1 and PD_OUT=latched WDATA.
- STROBE (STROBE_CYC cycles):
  - Select stays asserted.
  - _IOR=0 on a read, _IOW=0 on a write.
  - On a read, the edge ending the last STROBE cycle captures PD_IN into RDATA. RDATA holds until the next read completes.
- HOLD (HOLD_CYC cycles):
  - Strobe released.
  - Select and PD_DRIVE remain asserted.
- RECOVER (RECOV_CYC cycles):
  - Select released, PD_DRIVE=0.
  - ACK=1 in the first cycle after HOLD only. This is the first RECOVER cycle, or the first IDLE cycle when RECOV_CYC=0.
  - BUSY stays 1 through RECOVER and drops in the first IDLE cycle.
- Latency with defaults, REQ sampled at edge 0:
  - select low in cycles 1-5
  - strobe low in cycles 2-4
  - RDATA valid from cycle 5
  - ACK in cycle 6
  - BUSY low from cycle 8
  - next REQ accepted at edge 8
- REQ while BUSY=1 is ignored, not queued. The requester waits for BUSY=0.
- Only one of _CSS/_DACK is ever low. _IOR and _IOW are never both low except under PRESET.
- PRESET=1 at an edge (no RST):
  - _IOR=_IOW=0, _CSS=_DACK=1, PD_DRIVE=0.
  - State is forced to IDLE with BUSY=1; REQ is ignored.
  - Any in-flight cycle is aborted with no ACK and RDATA unchanged.
- On PRESET deassert: strobes return high at the next edge, BUSY=0 and the FSM is IDLE.
- RECOV_CYC=0: HOLD transitions directly to IDLE and REQ may be accepted in the same cycle ACK is high.

Test Plan:
- Reset: hold RST=1 for 2 cycles while REQ=1 and PRESET=1 -> all strobes/selects 1, BUSY=0, ACK=0, RDATA=0.
- Register read, defaults: REQ=1, RW=1, DMA=0, PD_IN=16'hA55A during strobe -> _CSS low cycles 1-5, _IOR low cycles 2-4, _DACK/_IOW stay 1, RDATA=16'hA55A from cycle 5, ACK=1 only in cycle 6, BUSY=0 from cycle 8.
- DMA write: REQ=1, RW=0, DMA=1, WDATA=16'h1234 -> _DACK low cycles 1-5, _IOW low cycles 2-4, PD_DRIVE=1 with PD_OUT=16'h1234 cycles 1-5, PD_DRIVE=0 in cycle 6.
- Back-to-back: REQ held high continuously -> second cycle starts at edge 8, REQ during cycles 1-7 has no effect, exactly one ACK per 8 cycles.
- PRESET mid-cycle: assert PRESET in cycle 3 of a read for 4 cycles -> _IOR=_IOW=0 and _CSS=1 during PRESET, no ACK, RDATA unchanged, IDLE with BUSY=0 one cycle after release.
- Parameters SETUP=2, STROBE=1, HOLD=1, RECOV=0 -> select low cycles 1-4, strobe low in cycle 3 only, ACK and BUSY=0 in cycle 5, new REQ accepted at edge 5.
